// File: rtl/updown_step_controller.sv
// updown_step_controller
//   Command-side initiator for an up/down counter. Accepts a target count on a
//   start/ready handshake, then walks the counter toward it one step at a time
//   along the shortest modular path, verifying each step against the counter's
//   returned state before issuing the next one.
//
// Ports
//   clk       system clock, all logic on the rising edge
//   reset     synchronous, active-high reset
//   start     request; accepted only while ready=1
//   target    requested final count, sampled on accept
//   ready     high only while idle
//   state_in  counter's current state (counter output)
//   up_down   counter command: 00 hold, 01 up by 1, 10 down by 1
//   busy      high while stepping, waiting or reporting done
//   done      one-cycle pulse, target reached
//   error     one-cycle pulse, counter failed to track within TIMEOUT cycles
//   steps     steps issued for the last/current request (saturating)
module updown_step_controller #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] target,
  output logic             ready,
  input  logic [WIDTH-1:0] state_in,
  output logic [1:0]       up_down,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [WIDTH:0]   steps
);

  localparam int unsigned     TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] HALF      = WIDTH'(2 ** (WIDTH - 1));

  localparam logic [1:0] CMD_HOLD = 2'b00;
  localparam logic [1:0] CMD_UP   = 2'b01;
  localparam logic [1:0] CMD_DOWN = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STEP,
    S_WAIT,
    S_DONE,
    S_ERROR
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] tgt;
  logic [WIDTH-1:0] expected;
  logic [TW-1:0]    timer;
  logic             dir_up;

  logic [WIDTH-1:0] dist_up;
  logic             go_up;

  // Upward distance from the current count to the requested target; a tie at
  // half the modulus resolves upward.
  always_comb begin
    dist_up = target - state_in;
    go_up   = (dist_up <= HALF);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      up_down  <= CMD_HOLD;
      ready    <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      steps    <= '0;
      tgt      <= '0;
      expected <= '0;
      timer    <= '0;
      dir_up   <= 1'b1;
    end else begin
      // Pulses and the command default low; only the transitions below raise them.
      done    <= 1'b0;
      error   <= 1'b0;
      up_down <= CMD_HOLD;

      case (state)
        S_IDLE: begin
          if (start) begin
            tgt   <= target;
            steps <= '0;
            ready <= 1'b0;
            busy  <= 1'b1;
            if (target == state_in) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              // Command is registered here so it is on the bus during STEP.
              state   <= S_STEP;
              dir_up  <= go_up;
              up_down <= go_up ? CMD_UP : CMD_DOWN;
            end
          end
        end

        S_STEP: begin
          // The counter applies the command at this edge; expect its new value next cycle.
          expected <= dir_up ? (state_in + 1'b1) : (state_in - 1'b1);
          if (steps != '1) begin
            steps <= steps + 1'b1;
          end
          timer <= '0;
          state <= S_WAIT;
        end

        S_WAIT: begin
          if (state_in == expected) begin
            if (expected == tgt) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state   <= S_STEP;
              up_down <= dir_up ? CMD_UP : CMD_DOWN;
            end
          end else if (timer == TIMER_LAST) begin
            state <= S_ERROR;
            error <= 1'b1;
            busy  <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          ready <= 1'b1;
        end

        S_ERROR: begin
          state <= S_IDLE;
          ready <= 1'b1;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_updown_step_controller.sv
// tb_updown_step_controller
//   Drives updown_step_controller against a behavioural 1-edge-latency up/down
//   counter (which can be frozen to emulate a stuck counter). Table of
//   requests with hand-derived expectations, scoreboard queue of completion
//   records, plus directed sequences for reset mid-request and start-while-busy.
module tb_updown_step_controller;

  localparam int unsigned WIDTH   = 4;
  localparam int unsigned TIMEOUT = 8;

  logic             clk;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] target;
  logic             ready;
  logic [WIDTH-1:0] state_in;
  logic [1:0]       up_down;
  logic             busy;
  logic             done;
  logic             error;
  logic [WIDTH:0]   steps;

  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             stuck;

  int tests;
  int fails;

  typedef struct {
    logic [WIDTH-1:0] init;
    logic [WIDTH-1:0] tgt;
    bit               stk;
    int               n;
    logic [1:0]       dir;
    bit               exp_err;
  } vec_t;

  typedef struct {
    bit d;
    bit e;
    int stp;
    int edges;
    int pulses;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  updown_step_controller #(
    .WIDTH  (WIDTH),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .target  (target),
    .ready   (ready),
    .state_in(state_in),
    .up_down (up_down),
    .busy    (busy),
    .done    (done),
    .error   (error),
    .steps   (steps)
  );

  // Counter model: command present at an edge updates the state at that edge.
  always_ff @(posedge clk) begin
    if (load) begin
      state_in <= load_val;
    end else if (!stuck) begin
      case (up_down)
        2'b01:   state_in <= state_in + 1'b1;
        2'b10:   state_in <= state_in - 1'b1;
        default: state_in <= state_in;
      endcase
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load_counter(input logic [WIDTH-1:0] v);
    @(negedge clk);
    load     = 1'b1;
    load_val = v;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic run_case(input vec_t v);
    exp_t e;
    exp_t got;
    int   k;
    int   pulses;
    int   violations;
    bit   prev_nz;
    bit   finished;

    stuck = v.stk;
    load_counter(v.init);

    e.d      = !v.exp_err;
    e.e      = v.exp_err;
    e.stp    = v.n;
    e.edges  = v.exp_err ? (1 + TIMEOUT) : (2 * v.n);
    e.pulses = v.n;
    sb.push_back(e);

    check("ready_before_start", int'(ready), 1);
    start  = 1'b1;
    target = v.tgt;
    @(negedge clk);
    start  = 1'b0;
    target = ~v.tgt;  // post-accept target changes must be ignored

    k          = 0;
    pulses     = 0;
    violations = 0;
    prev_nz    = 1'b0;
    finished   = 1'b0;
    for (int c = 0; c < 200 && !finished; c++) begin
      if (up_down != 2'b00) begin
        pulses++;
        if (up_down != v.dir || prev_nz) violations++;
      end
      prev_nz = (up_down != 2'b00);
      if (done || error) begin
        finished = 1'b1;
      end else begin
        @(negedge clk);
        k++;
      end
    end

    check("completion_seen", int'(finished), 1);
    got = sb.pop_front();
    if (finished) begin
      check("done_flag", int'(done), int'(got.d));
      check("error_flag", int'(error), int'(got.e));
      check("steps_count", int'(steps), got.stp);
      check("edges_to_result", k, got.edges);
      check("busy_at_result", int'(busy), int'(got.d));
      check("ready_at_result", int'(ready), 0);
    end
    check("cmd_pulses", pulses, got.pulses);
    check("cmd_pattern_violations", violations, 0);
    check("counter_final", int'(state_in), int'(v.stk ? v.init : v.tgt));

    @(negedge clk);
    check("ready_after", int'(ready), 1);
    check("busy_after", int'(busy), 0);
    check("done_one_cycle", int'(done), 0);
    check("error_one_cycle", int'(error), 0);
    check("steps_hold", int'(steps), v.n);
    stuck = 1'b0;
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    reset    = 1'b1;
    start    = 1'b0;
    target   = '0;
    load     = 1'b1;
    load_val = '0;
    stuck    = 1'b0;

    //           init    tgt   stuck n  dir    err
    vecs[0] = '{4'd3,  4'd6,  1'b0, 3, 2'b01, 1'b0};
    vecs[1] = '{4'd14, 4'd1,  1'b0, 3, 2'b01, 1'b0};
    vecs[2] = '{4'd1,  4'd14, 1'b0, 3, 2'b10, 1'b0};
    vecs[3] = '{4'd0,  4'd8,  1'b0, 8, 2'b01, 1'b0};
    vecs[4] = '{4'd5,  4'd5,  1'b0, 0, 2'b01, 1'b0};
    vecs[5] = '{4'd2,  4'd4,  1'b1, 1, 2'b01, 1'b1};
    vecs[6] = '{4'd8,  4'd0,  1'b0, 8, 2'b01, 1'b0};
    vecs[7] = '{4'd10, 4'd3,  1'b0, 7, 2'b10, 1'b0};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    load  = 1'b0;
    check("reset_ready", int'(ready), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_error", int'(error), 0);
    check("reset_up_down", int'(up_down), 0);
    check("reset_steps", int'(steps), 0);

    foreach (vecs[i]) run_case(vecs[i]);

    // start while busy is ignored: request 3->6, pulse start with 12 mid-run.
    begin
      int  k;
      bit  finished;
      load_counter(4'd3);
      start  = 1'b1;
      target = 4'd6;
      @(negedge clk);
      start    = 1'b0;
      k        = 0;
      finished = 1'b0;
      for (int c = 0; c < 60 && !finished; c++) begin
        if (done || error) begin
          finished = 1'b1;
        end else begin
          start  = (c == 1);
          target = (c == 1) ? 4'd12 : 4'd6;
          @(negedge clk);
          k++;
        end
      end
      start = 1'b0;
      check("busy_start_finished", int'(finished), 1);
      check("busy_start_done", int'(done), 1);
      check("busy_start_steps", int'(steps), 3);
      check("busy_start_edges", k, 6);
      check("busy_start_counter", int'(state_in), 6);
      repeat (2) @(negedge clk);
      check("busy_start_not_queued_busy", int'(busy), 0);
      check("busy_start_not_queued_cmd", int'(up_down), 0);
      check("busy_start_counter_still", int'(state_in), 6);
    end

    // Reset during WAIT of a 3->10 request.
    load_counter(4'd3);
    start  = 1'b1;
    target = 4'd10;
    @(negedge clk);
    start = 1'b0;
    check("rst_mid_step_cmd", int'(up_down), 1);
    @(negedge clk);
    check("rst_mid_wait_cmd", int'(up_down), 0);
    check("rst_mid_wait_busy", int'(busy), 1);
    check("rst_mid_wait_steps", int'(steps), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_ready", int'(ready), 1);
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_up_down", int'(up_down), 0);
    check("rst_mid_steps", int'(steps), 0);
    check("rst_mid_done", int'(done), 0);
    @(negedge clk);
    check("rst_no_retry_cmd", int'(up_down), 0);
    check("rst_no_retry_counter", int'(state_in), 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
